// File: rtl/trace_packet_funnel_pkg.sv
// trace_packet_funnel_pkg: shared widths, typedefs and configuration helpers for the trace funnel
package trace_packet_funnel_pkg;
    localparam int DEF_WORD_W = 32;
    localparam int MAX_NCH = 16;
    typedef logic [DEF_WORD_W-1:0] word_t;
    typedef logic [$clog2(MAX_NCH)-1:0] id_t;
    function automatic int id_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction
    function automatic bit cfg_legal(input int nch, input int depth);
        return nch >= 1 && nch <= MAX_NCH && depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/trace_packet_funnel_rr_arbiter.sv
// trace_packet_funnel_rr_arbiter: round-robin grant with pointer advancing past each winner
module trace_packet_funnel_rr_arbiter #(
    parameter int NCH  = 2,
    parameter int ID_W = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NCH-1:0]  req,
    input  logic            grant_en,
    output logic [NCH-1:0]  grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_vld
);
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] k;
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        k = '0;
        for (int i = 0; i < NCH; i++) begin
            k = ID_W'((int'(ptr) + i) % NCH);
            if (!grant_vld && req[k]) begin
                grant_vld = 1'b1;
                grant_idx = k;
            end
        end
    end
    assign grant = grant_vld ? (NCH'(1) << grant_idx) : '0;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            ptr <= '0;
        else if (grant_en && grant_vld)
            ptr <= (grant_idx == ID_W'(NCH - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/trace_packet_funnel.sv
// trace_packet_funnel: buffers NCH trace word streams and merges them round-robin into one tagged stream
module trace_packet_funnel
    import trace_packet_funnel_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8,
    localparam int ID_W  = id_width(NCH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NCH*WORD_W-1:0] packet_word_i,
    input  logic [NCH-1:0]        packet_word_valid_i,
    output logic [NCH-1:0]        stall_o,
    output logic [WORD_W-1:0]     word_o,
    output logic [ID_W-1:0]       src_id_o,
    output logic                  word_valid_o,
    input  logic                  stall_i,
    input  logic                  clear_i,
    output logic [NCH-1:0]        overflow_o,
    output logic [NCH*DROP_W-1:0] drop_cnt_o
);
    localparam int PW = $clog2(DEPTH) + 1;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    grant;
    logic [NCH-1:0]    pop;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_vld;
    logic              load;
    logic [WORD_W-1:0] head [NCH];
    assign load = !word_valid_o || !stall_i;
    assign pop = load ? grant : '0;
    trace_packet_funnel_rr_arbiter #(.NCH(NCH), .ID_W(ID_W)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req       (req),
        .grant_en  (load),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WORD_W-1:0] mem [DEPTH];
        logic [PW-1:0]     wptr;
        logic [PW-1:0]     rptr;
        logic [PW-1:0]     cnt;
        logic [PW-1:0]     cnt_nxt;
        logic              push;
        logic              drop;
        logic              stall_r;
        logic              ovf_r;
        logic [DROP_W-1:0] dcnt;
        assign cnt = wptr - rptr;
        // a full FIFO still accepts when its head leaves in the same cycle
        assign push = packet_word_valid_i[c] && (cnt < PW'(DEPTH) || pop[c]);
        assign drop = packet_word_valid_i[c] && !push;
        assign cnt_nxt = cnt + PW'(push) - PW'(pop[c]);
        assign req[c] = cnt != '0;
        assign head[c] = mem[rptr[PW-2:0]];
        assign stall_o[c] = stall_r;
        assign overflow_o[c] = ovf_r;
        assign drop_cnt_o[c*DROP_W +: DROP_W] = dcnt;
        always_ff @(posedge clk_i)
            if (push)
                mem[wptr[PW-2:0]] <= packet_word_i[c*WORD_W +: WORD_W];
        always_ff @(posedge clk_i or posedge rst_i)
            if (rst_i) begin
                wptr    <= '0;
                rptr    <= '0;
                stall_r <= 1'b0;
                ovf_r   <= 1'b0;
                dcnt    <= '0;
            end else begin
                wptr    <= wptr + PW'(push);
                rptr    <= rptr + PW'(pop[c]);
                stall_r <= cnt_nxt >= PW'(DEPTH - 1);
                ovf_r   <= drop || (ovf_r && !clear_i);
                dcnt    <= drop ? (clear_i ? DROP_W'(1) : dcnt + DROP_W'(dcnt != '1))
                                : (clear_i ? '0 : dcnt);
            end
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            word_o       <= '0;
            src_id_o     <= '0;
            word_valid_o <= 1'b0;
        end else if (load) begin
            word_valid_o <= grant_vld;
            if (grant_vld) begin
                word_o   <= head[grant_idx];
                src_id_o <= grant_idx;
            end
        end
endmodule

// File: tb/tb_trace_packet_funnel.sv
// tb_trace_packet_funnel: directed stimulus with per-channel scoreboard queues checked by an output monitor
module tb_trace_packet_funnel;
    localparam int NCH = 2, WORD_W = 32, DEPTH = 4, DROP_W = 8, ID_W = 1;
    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NCH*WORD_W-1:0] packet_word_i;
    logic [NCH-1:0]        packet_word_valid_i;
    logic [NCH-1:0]        stall_o;
    logic [WORD_W-1:0]     word_o;
    logic [ID_W-1:0]       src_id_o;
    logic                  word_valid_o;
    logic                  stall_i;
    logic                  clear_i;
    logic [NCH-1:0]        overflow_o;
    logic [NCH*DROP_W-1:0] drop_cnt_o;
    int n_cmp = 0;
    int n_fail = 0;
    logic [WORD_W-1:0] expq [NCH][$];
    int got_ids[$];
    bit log_en = 1'b0;

    trace_packet_funnel #(.NCH(NCH), .WORD_W(WORD_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .packet_word_i       (packet_word_i),
        .packet_word_valid_i (packet_word_valid_i),
        .stall_o             (stall_o),
        .word_o              (word_o),
        .src_id_o            (src_id_o),
        .word_valid_o        (word_valid_o),
        .stall_i             (stall_i),
        .clear_i             (clear_i),
        .overflow_o          (overflow_o),
        .drop_cnt_o          (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i)
        if (!rst_i && word_valid_o && !stall_i) begin
            if (log_en) got_ids.push_back(int'(src_id_o));
            if (expq[src_id_o].size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h on ch%0d with nothing expected", word_o, src_id_o);
            end else
                chk($sformatf("word_ch%0d", src_id_o), word_o, expq[src_id_o].pop_front());
        end

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_w(input int c, input logic v, input logic [WORD_W-1:0] w);
        packet_word_valid_i[c] = v;
        packet_word_i[c*WORD_W +: WORD_W] = w;
    endtask

    task automatic send(input int c, input logic [WORD_W-1:0] w);
        set_w(c, 1'b1, w);
        expq[c].push_back(w);
    endtask

    task automatic drain;
        for (int i = 0; i < 200; i++) begin
            if (expq[0].size() == 0 && expq[1].size() == 0 && !word_valid_o) return;
            step;
        end
        chk("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent [NCH];
        rst_i = 1'b1;
        stall_i = 1'b0;
        clear_i = 1'b0;
        packet_word_valid_i = '0;
        packet_word_i = '0;
        #12;
        chk("rst_valid", word_valid_o, 0);
        chk("rst_word", word_o, 0);
        chk("rst_id", src_id_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        rst_i = 1'b0;
        step;
        // single word latency
        send(0, 32'hA5A5_0001);
        step;
        set_w(0, 1'b0, '0);
        chk("lat_t1_valid", word_valid_o, 0);
        step;
        chk("lat_t2_valid", word_valid_o, 1);
        chk("lat_t2_id", src_id_o, 0);
        chk("lat_t2_word", word_o, 32'hA5A5_0001);
        drain;
        // both channels streaming, sources honour stall_o
        got_ids.delete();
        log_en = 1'b1;
        sent[0] = 0;
        sent[1] = 0;
        for (int cy = 0; cy < 60 && (sent[0] < 6 || sent[1] < 6); cy++) begin
            for (int c = 0; c < NCH; c++)
                if (sent[c] < 6 && !stall_o[c]) begin
                    send(c, 32'h1000 + c * 256 + sent[c]);
                    sent[c]++;
                end else
                    set_w(c, 1'b0, '0);
            step;
        end
        set_w(0, 1'b0, '0);
        set_w(1, 1'b0, '0);
        drain;
        log_en = 1'b0;
        chk("alt_count", got_ids.size(), 12);
        for (int i = 1; i < got_ids.size(); i++)
            chk($sformatf("alt_id_%0d", i), got_ids[i] != got_ids[i-1], 1);
        chk("alt_drop", drop_cnt_o, 0);
        chk("alt_ovf", overflow_o, 0);
        // sink stalls while ch1 streams
        stall_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (!stall_o[1]) send(1, 32'h3000 + k);
            else set_w(1, 1'b0, '0);
            step;
            chk($sformatf("stall_o1_k%0d", k), stall_o[1], k >= 4);
            if (k >= 2) begin
                chk($sformatf("hold_valid_k%0d", k), word_valid_o, 1);
                chk($sformatf("hold_word_k%0d", k), word_o, 32'h3001);
                chk($sformatf("hold_id_k%0d", k), src_id_o, 1);
            end
        end
        set_w(1, 1'b0, '0);
        chk("stall_drop1", drop_cnt_o[DROP_W +: DROP_W], 0);
        stall_i = 1'b0;
        drain;
        // source ignores stall_o: overflow, saturation, clear
        stall_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i < 5) send(0, 32'hC000 + i);
            else set_w(0, 1'b1, 32'hC000 + i);
            step;
        end
        set_w(0, 1'b0, '0);
        chk("ovf0", overflow_o[0], 1);
        chk("drop0_6", drop_cnt_o[DROP_W-1:0], 6);
        chk("ovf1", overflow_o[1], 0);
        chk("stall_o0_full", stall_o[0], 1);
        set_w(0, 1'b1, 32'hDEAD);
        repeat (300) step;
        set_w(0, 1'b0, '0);
        chk("drop0_sat", drop_cnt_o[DROP_W-1:0], 255);
        clear_i = 1'b1;
        step;
        clear_i = 1'b0;
        chk("clear_drop0", drop_cnt_o[DROP_W-1:0], 0);
        chk("clear_ovf0", overflow_o[0], 0);
        clear_i = 1'b1;
        set_w(0, 1'b1, 32'hBEEF);
        step;
        clear_i = 1'b0;
        set_w(0, 1'b0, '0);
        chk("clear_drop_drop0", drop_cnt_o[DROP_W-1:0], 1);
        chk("clear_drop_ovf0", overflow_o[0], 1);
        stall_i = 1'b0;
        drain;
        // asynchronous reset with words buffered
        stall_i = 1'b1;
        set_w(0, 1'b1, 32'hE000);
        set_w(1, 1'b1, 32'hE100);
        step;
        set_w(0, 1'b1, 32'hE001);
        set_w(1, 1'b1, 32'hE101);
        step;
        set_w(0, 1'b0, '0);
        set_w(1, 1'b0, '0);
        step;
        chk("pre_rst_valid", word_valid_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_valid", word_valid_o, 0);
        chk("arst_word", word_o, 0);
        chk("arst_id", src_id_o, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_ovf", overflow_o, 0);
        chk("arst_drop", drop_cnt_o, 0);
        #3 rst_i = 1'b0;
        stall_i = 1'b0;
        step;
        send(1, 32'hF001);
        step;
        send(1, 32'hF002);
        send(0, 32'hF100);
        step;
        set_w(0, 1'b0, '0);
        set_w(1, 1'b0, '0);
        chk("post_rst_valid", word_valid_o, 1);
        chk("post_rst_id", src_id_o, 1);
        chk("post_rst_word", word_o, 32'hF001);
        drain;
        chk("sb_empty", expq[0].size() + expq[1].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
